muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide unit that extends the single-cycle ALU path with the M extension.

---
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Operands are latched on an accepted start; the result is registered and held between operations.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take operand magnitudes, catch divide-by-zero / signed overflow
// CALC  | one multiply or divide iteration per cycle
// FIX   | sign correction and result selection
// DONE  | result valid, done pulse
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      f_q, f_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic              sign_a, sign_b, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_raw, prod_fix;

    // In PREP, lo_q still holds op_a and mcand_q holds op_b.
    assign sign_a = (f_q == 3'b001) || (f_q == 3'b010) || (f_q == 3'b100) || (f_q == 3'b110);
    assign sign_b = (f_q == 3'b001) || (f_q == 3'b100) || (f_q == 3'b110);
    assign a_neg  = sign_a & lo_q[XLEN-1];
    assign b_neg  = sign_b & mcand_q[XLEN-1];
    assign abs_a  = a_neg ? -lo_q : lo_q;
    assign abs_b  = b_neg ? -mcand_q : mcand_q;

    // Multiply: {hi,lo} holds partial product above the not-yet-consumed multiplier bits.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {XLEN{1'b0}})};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_sub   = div_shift[XLEN-1:0] - mcand_q;

    assign prod_raw = {hi_q, lo_q};
    assign prod_fix = qneg_q ? -prod_raw : prod_raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f_d      = f_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_PREP;
                    f_d     = funct3;
                    lo_d    = op_a;
                    mcand_d = op_b;
                end
            end
            S_PREP: begin
                if (f_q[2] && (mcand_q == '0)) begin
                    result_d = f_q[1] ? lo_q : {XLEN{1'b1}};
                    state_d  = S_DONE;
                end else if (f_q[2] && !f_q[0] && (lo_q == MOST_NEG) && (mcand_q == {XLEN{1'b1}})) begin
                    result_d = f_q[1] ? {XLEN{1'b0}} : lo_q;
                    state_d  = S_DONE;
                end else begin
                    hi_d    = '0;
                    lo_d    = abs_a;
                    mcand_d = abs_b;
                    cnt_d   = CNT_W'(XLEN);
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (f_q[2]) begin
                    hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (f_q[2])
                    result_d = f_q[1] ? (rneg_q ? -hi_q : hi_q) : (qneg_q ? -lo_q : lo_q);
                else
                    result_d = (f_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f_q      <= f_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq at XLEN=32 and XLEN=8 against an arithmetic reference.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  f32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] result32;

    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  f8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  result8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .flush(flush32), .funct3(f32),
        .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_seq #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .flush(flush8), .funct3(f8),
        .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .result(result8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics computed with 64-bit integer arithmetic, truncated to w bits.
    function automatic logic [31:0] model(input int w, input logic [2:0] f,
                                          input logic [31:0] a_in, input logic [31:0] b_in);
        longint m, ua, ub, sa, sb, p, r, most_neg;
        m  = (longint'(1) << w) - 1;
        ua = longint'({32'b0, a_in}) & m;
        ub = longint'({32'b0, b_in}) & m;
        sa = ua[w-1] ? ua - (m + 1) : ua;
        sb = ub[w-1] ? ub - (m + 1) : ub;
        most_neg = -(longint'(1) << (w - 1));
        case (f)
            3'b000: begin p = ua * ub; r = p; end
            3'b001: begin p = sa * sb; r = p >>> w; end
            3'b010: begin p = sa * ub; r = p >>> w; end
            3'b011: begin p = ua * ub; r = p >> w; end
            3'b100: r = (ub == 0) ? -1 : ((sa == most_neg && sb == -1) ? sa : sa / sb);
            3'b101: r = (ub == 0) ? m : ua / ub;
            3'b110: r = (ub == 0) ? sa : ((sa == most_neg && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & m);
    endfunction

    function automatic int exp_lat(input int w, input logic [2:0] f,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        longint m, ua, ub;
        m  = (longint'(1) << w) - 1;
        ua = longint'({32'b0, a_in}) & m;
        ub = longint'({32'b0, b_in}) & m;
        if (f >= 3'd4 && ub == 0) return 2;
        if ((f == 3'b100 || f == 3'b110) && ua == (longint'(1) << (w - 1)) && ub == m) return 2;
        return w + 3;
    endfunction

    // Issues one request and watches 60 cycles; optional flush / stray start at cycle t+n.
    task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int poke_at,
                         output int lat, output int bcnt, output int dcnt, output logic busy_post_flush);
        @(negedge clk);
        start32 = 1'b1; f32 = f; a32 = a; b32 = b;
        @(posedge clk);
        #1;
        start32 = 1'b0; f32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
        lat = -1; bcnt = 0; dcnt = 0; busy_post_flush = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done32) begin
                dcnt++;
                if (lat < 0) lat = n;
            end else if (busy32) bcnt++;
            if (n == flush_at + 1) busy_post_flush = busy32;
            start32 = (n == poke_at);
            if (n == poke_at) begin f32 = 3'($urandom); a32 = $urandom; b32 = $urandom; end
            flush32 = (n == flush_at);
        end
        start32 = 1'b0; flush32 = 1'b0;
    endtask

    task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        start8 = 1'b1; f8 = f; a8 = a; b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done8 && lat < 0) lat = n;
        end
    endtask

    typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] exp; string tag; } vec_t;

    initial begin
        vec_t        dir[$];
        int          lat, bcnt, dcnt;
        logic        bpf;
        logic [31:0] a, b, held;
        logic [2:0]  f;

        repeat (2) @(negedge clk);
        check_eq("reset_busy", 32'(busy32), 32'd0);
        check_eq("reset_done", 32'(done32), 32'd0);
        check_eq("reset_result", result32, 32'd0);
        rst_n = 1'b1;

        run32(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0, lat, bcnt, dcnt, bpf);
        check_eq("mul_result", result32, 32'hFFFF_FFEB);
        check_eq("mul_latency", 32'(lat), 32'd35);
        check_eq("mul_busy_cycles", 32'(bcnt), 32'd34);
        check_eq("mul_done_pulses", 32'(dcnt), 32'd1);

        dir.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min"});
        dir.push_back('{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min"});
        dir.push_back('{3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, "mulhsu_min"});
        dir.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_zero"});
        dir.push_back('{3'b111, 32'd5, 32'd0, 32'd5, "remu_zero"});
        dir.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
        dir.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf"});
        dir.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg"});
        dir.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg"});
        dir.push_back('{3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7"});
        foreach (dir[i]) begin
            run32(dir[i].f, dir[i].a, dir[i].b, 0, 0, lat, bcnt, dcnt, bpf);
            check_eq(dir[i].tag, result32, dir[i].exp);
            check_eq({dir[i].tag, "_lat"}, 32'(lat), 32'(exp_lat(32, dir[i].f, dir[i].a, dir[i].b)));
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run32(f, a, b, 0, 0, lat, bcnt, dcnt, bpf);
            check_eq("rand_result", result32, model(32, f, a, b));
            check_eq("rand_latency", 32'(lat), 32'(exp_lat(32, f, a, b)));
            check_eq("rand_done_pulses", 32'(dcnt), 32'd1);
        end

        held = result32;
        run32(3'b100, 32'd1000, 32'd3, 10, 0, lat, bcnt, dcnt, bpf);
        check_eq("flush_no_done", 32'(dcnt), 32'd0);
        check_eq("flush_busy_low", 32'(bpf), 32'd0);
        check_eq("flush_result_held", result32, held);
        run32(3'b101, 32'd1000, 32'd3, 0, 0, lat, bcnt, dcnt, bpf);
        check_eq("after_flush_result", result32, 32'd333);
        check_eq("after_flush_latency", 32'(lat), 32'd35);

        run32(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 0, 5, lat, bcnt, dcnt, bpf);
        check_eq("busy_start_result", result32, model(32, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678));
        check_eq("busy_start_latency", 32'(lat), 32'd35);
        check_eq("busy_start_busy", 32'(bcnt), 32'd34);
        run32(3'b000, 32'd9, 32'd9, 0, 35, lat, bcnt, dcnt, bpf);
        check_eq("done_start_result", result32, 32'd81);
        check_eq("done_start_ignored", 32'(bcnt), 32'd34);
        check_eq("done_start_pulses", 32'(dcnt), 32'd1);

        @(negedge clk);
        start32 = 1'b1; f32 = 3'b000; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", 32'(busy32), 32'd0);
        check_eq("async_rst_done", 32'(done32), 32'd0);
        check_eq("async_rst_result", result32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done32) lat = n;
        end
        check_eq("async_rst_no_done", 32'(lat), 32'hFFFF_FFFF);

        run8(3'b000, 8'h0F, 8'h11, lat);
        check_eq("x8_mul", {24'b0, result8}, 32'h0000_00FF);
        check_eq("x8_mul_latency", 32'(lat), 32'd11);
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = {24'b0, 8'($urandom)};
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : {24'b0, 8'($urandom)};
            if ($urandom_range(0, 5) == 0) begin a = 32'h80; b = 32'hFF; end
            run8(f, a[7:0], b[7:0], lat);
            check_eq("x8_rand_result", {24'b0, result8}, model(8, f, a, b));
            check_eq("x8_rand_latency", 32'(lat), 32'(exp_lat(8, f, a, b)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
